// File: rtl/stream_selector.sv
// Packet-aware stream selector: picks one of CHANNELS input streams (fixed select or
// round-robin) and forwards whole packets through a single registered output stage.
module stream_selector #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [CHANNELS-1:0]       i_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_last,
    output logic [CHANNELS-1:0]       o_ready,
    output logic                      o_valid,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_last,
    output logic [SEL_W-1:0]          o_chan,
    input  logic                      i_ready
);

    localparam logic [SEL_W:0]   CH_N    = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_q, lock_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               last_q, last_d;
    logic [SEL_W-1:0]   chan_q, chan_d;

    logic                  load_en;
    logic                  grant;
    logic [SEL_W-1:0]      gnt_ch;
    logic                  sel_valid;
    logic                  sel_last;
    logic [WIDTH-1:0]      sel_data;
    logic                  xfer;

    logic [2*CHANNELS-1:0] req_dbl;
    logic [2*CHANNELS-1:0] req_shift;
    logic [CHANNELS-1:0]   req_rot;
    logic [SEL_W:0]        rr_start;
    logic [SEL_W:0]        rr_off;
    logic [SEL_W:0]        rr_sum;
    logic                  rr_found;
    logic [SEL_W-1:0]      rr_ch;

    assign load_en = ~valid_q | i_ready;

    // Rotate requests so bit 0 is the channel just after ptr; the lowest set bit wins.
    always_comb begin
        req_dbl   = {i_valid, i_valid};
        rr_start  = {1'b0, ptr_q} + (SEL_W + 1)'(1);
        req_shift = req_dbl >> rr_start;
        req_rot   = req_shift[CHANNELS-1:0];
        rr_found  = 1'b0;
        rr_off    = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rr_found = 1'b1;
                rr_off   = (SEL_W + 1)'(k);
            end
        end
        rr_sum = rr_start + rr_off;
        rr_ch  = (rr_sum >= CH_N) ? SEL_W'(rr_sum - CH_N) : SEL_W'(rr_sum);
    end

    always_comb begin
        grant  = 1'b0;
        gnt_ch = '0;
        if (state_q == ST_LOCKED) begin
            grant  = 1'b1;
            gnt_ch = lock_q;
        end else if (!i_mode) begin
            grant  = ({1'b0, i_sel} < CH_N);
            gnt_ch = i_sel;
        end else begin
            grant  = rr_found;
            gnt_ch = rr_ch;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        o_ready   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt_ch == SEL_W'(k)) begin
                sel_valid  = i_valid[k];
                sel_last   = i_last[k];
                sel_data   = i_data[k*WIDTH +: WIDTH];
                o_ready[k] = grant & load_en & ~i_rst;
            end
        end
    end

    assign xfer = grant & sel_valid & load_en;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        chan_d  = chan_q;
        if (load_en) begin
            valid_d = xfer;
        end
        if (xfer) begin
            data_d = sel_data;
            last_d = sel_last;
            chan_d = gnt_ch;
            if (sel_last) begin
                state_d = ST_IDLE;
                ptr_d   = gnt_ch;
            end else begin
                state_d = ST_LOCKED;
                lock_d  = gnt_ch;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            ptr_q   <= PTR_RST;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_chan  = chan_q;

endmodule

// File: tb/tb_stream_selector.sv
// Bench for stream_selector: per-channel source queues, a packet-level reference model
// checked every cycle, and directed scenarios with literal expected output sequences.
module tb_stream_selector;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int EW = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            mode = 1'b0;
    logic [1:0]      sel = 2'd0;
    logic [CH-1:0]   valid = '0;
    logic [CH*W-1:0] data = '0;
    logic [CH-1:0]   last = '0;
    logic            ready_in = 1'b1;
    logic [CH-1:0]   o_ready;
    logic            o_valid;
    logic [W-1:0]    o_data;
    logic            o_last;
    logic [1:0]      o_chan;

    logic            mode3 = 1'b0;
    logic [1:0]      sel3 = 2'd3;
    logic [2:0]      valid3 = 3'b111;
    logic [3*W-1:0]  data3 = {8'hC2, 8'hC1, 8'hC0};
    logic [2:0]      last3 = 3'b111;
    logic            ready3 = 1'b1;
    logic [2:0]      o_ready3;
    logic            o_valid3;
    logic [W-1:0]    o_data3;
    logic            o_last3;
    logic [1:0]      o_chan3;

    stream_selector #(.WIDTH(W), .CHANNELS(CH)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel),
        .i_valid(valid), .i_data(data), .i_last(last),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
        .o_last(o_last), .o_chan(o_chan), .i_ready(ready_in)
    );

    stream_selector #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode3), .i_sel(sel3),
        .i_valid(valid3), .i_data(data3), .i_last(last3),
        .o_ready(o_ready3), .o_valid(o_valid3), .o_data(o_data3),
        .o_last(o_last3), .o_chan(o_chan3), .i_ready(ready3)
    );

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    // Beats are packed as {last, chan[1:0], data[7:0]}.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] out_log[$];
    int            out_cyc[$];
    logic [EW-1:0] want[$];

    logic [7:0]    src_d[CH][$];
    logic          src_l[CH][$];
    logic [CH-1:0] gap = '0;
    logic [CH-1:0] xfer_s = '0;

    bit m_busy = 0;
    int m_ch = 0;
    int m_ptr = CH - 1;

    bit            pred_pop = 0;
    bit            pred_xfer = 0;
    bit            pred_last = 0;
    int            pred_ch = 0;
    logic [EW-1:0] pred_beat = '0;
    bit            trk_r3 = 0;
    bit            r3_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Packet-level rule: a packet in flight owns the output; otherwise fixed select or
    // the first requester after the last-served channel.
    function automatic int model_grant();
        if (m_busy) return m_ch;
        if (!mode) return (int'(sel) < CH) ? int'(sel) : -1;
        for (int i = 1; i <= CH; i++) begin
            if (valid[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
        end
        return -1;
    endfunction

    function automatic bit busy_src();
        for (int k = 0; k < CH; k++) if (src_d[k].size() != 0) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [CH-1:0] er;
        cyc++;
        if (rst) begin
            chk("rst_o_ready", 32'(o_ready), 0);
            chk("rst_o_valid", 32'(o_valid), 0);
            chk("rst_o_data", 32'(o_data), 0);
            chk("rst_o_last", 32'(o_last), 0);
            chk("rst_o_chan", 32'(o_chan), 0);
            pred_pop  = 0;
            pred_xfer = 0;
            xfer_s    = '0;
        end else begin
            g  = model_grant();
            er = '0;
            if (g >= 0 && (exp_q.size() == 0 || ready_in)) er[g] = 1'b1;
            chk("o_ready", 32'(o_ready), 32'(er));
            chk("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("o_beat", 32'({o_last, o_chan, o_data}), 32'(exp_q[0]));
            pred_pop  = (exp_q.size() != 0) && ready_in;
            pred_xfer = 0;
            if (er != 0) begin
                pred_xfer = valid[g];
                pred_last = last[g];
                pred_ch   = g;
                pred_beat = {last[g], 2'(g), data[g*W +: W]};
            end
            xfer_s = o_ready & valid;
            if (o_valid && ready_in) begin
                out_log.push_back({o_last, o_chan, o_data});
                out_cyc.push_back(cyc);
            end
            if (trk_r3 && o_ready[3]) r3_seen = 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_busy = 0;
            m_ch   = 0;
            m_ptr  = CH - 1;
        end else begin
            if (pred_pop) void'(exp_q.pop_front());
            if (pred_xfer) begin
                exp_q.push_back(pred_beat);
                if (pred_last) begin
                    m_busy = 0;
                    m_ptr  = pred_ch;
                end else begin
                    m_busy = 1;
                    m_ch   = pred_ch;
                end
            end
        end
    end

    task automatic drive_inputs();
        for (int k = 0; k < CH; k++) begin
            valid[k]       = (src_d[k].size() != 0) && !gap[k];
            data[k*W +: W] = (src_d[k].size() != 0) ? src_d[k][0] : 8'h00;
            last[k]        = (src_l[k].size() != 0) ? src_l[k][0] : 1'b0;
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        src_d[k].push_back(d);
        src_l[k].push_back(l);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < CH; k++) begin
            if (xfer_s[k] && src_d[k].size() != 0) begin
                void'(src_d[k].pop_front());
                void'(src_l[k].pop_front());
            end
        end
        xfer_s = '0;
        #1;
        drive_inputs();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int k = 0; k < CH; k++) begin
            src_d[k].delete();
            src_l[k].delete();
        end
        gap = '0;
        drive_inputs();
        repeat (2) cycle();
        rst = 1'b0;
        out_log.delete();
        out_cyc.delete();
    endtask

    task automatic run_idle(input string name);
        int n = 0;
        while ((busy_src() || exp_q.size() != 0) && n < 100) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, 32'(n < 100), 1);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, out_log.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            chk(name, (i < out_log.size()) ? 32'(out_log[i]) : 32'hFFFF_FFFF, 32'(want[i]));
        end
    endtask

    task automatic chk_b2b(input string name);
        for (int i = 1; i < out_cyc.size(); i++) chk(name, out_cyc[i] - out_cyc[i-1], 1);
    endtask

    initial begin
        int n;
        #2;
        reset_dut();

        // Fixed select, three-beat packet on channel 2.
        mode = 1'b0;
        sel  = 2'd2;
        push(2, 8'h11, 0);
        push(2, 8'h22, 0);
        push(2, 8'h33, 1);
        drive_inputs();
        run_idle("fixed_pkt");
        want = '{11'h211, 11'h222, 11'h633};
        chk_log("fixed_pkt_seq");
        chk_b2b("fixed_pkt_b2b");

        // Round-robin over single-beat packets, channel 0 first after reset.
        reset_dut();
        mode = 1'b1;
        push(0, 8'hA0, 1);
        push(0, 8'hA4, 1);
        push(1, 8'hA1, 1);
        push(2, 8'hA2, 1);
        push(3, 8'hA3, 1);
        drive_inputs();
        run_idle("rr");
        want = '{11'h4A0, 11'h5A1, 11'h6A2, 11'h7A3, 11'h4A4};
        chk_log("rr_seq");
        chk_b2b("rr_b2b");

        // Select moves away mid-packet, with a valid gap on the locked channel.
        reset_dut();
        mode = 1'b0;
        sel  = 2'd1;
        push(1, 8'h41, 0);
        push(1, 8'h42, 0);
        push(1, 8'h43, 0);
        push(1, 8'h44, 1);
        push(3, 8'h71, 0);
        push(3, 8'h72, 1);
        trk_r3  = 1;
        r3_seen = 0;
        drive_inputs();
        n = 0;
        while (src_d[1].size() != 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("lock_two_sent", 32'(src_d[1].size()), 2);
        sel    = 2'd3;
        gap[1] = 1'b1;
        drive_inputs();
        repeat (2) cycle();
        gap[1] = 1'b0;
        drive_inputs();
        n = 0;
        while (src_d[1].size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        trk_r3 = 0;
        chk("lock_r3_low", 32'(r3_seen), 0);
        run_idle("lock");
        want = '{11'h141, 11'h142, 11'h143, 11'h544, 11'h371, 11'h772};
        chk_log("lock_seq");

        // Downstream stall with a held beat.
        reset_dut();
        mode     = 1'b0;
        sel      = 2'd0;
        ready_in = 1'b0;
        push(0, 8'h5A, 1);
        push(0, 8'h5B, 1);
        drive_inputs();
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("stall_o_valid", 32'(o_valid), 1);
            chk("stall_o_data", 32'(o_data), 32'h5A);
            chk("stall_o_ready", 32'(o_ready), 0);
            if (i < 3) cycle();
        end
        ready_in = 1'b1;
        run_idle("stall");
        want = '{11'h45A, 11'h45B};
        chk_log("stall_seq");

        // Asynchronous reset in the middle of a channel 0 packet.
        reset_dut();
        mode = 1'b1;
        push(0, 8'h81, 0);
        push(0, 8'h82, 0);
        push(0, 8'h83, 1);
        drive_inputs();
        cycle();
        chk("arst_pre_valid", 32'(o_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_o_valid", 32'(o_valid), 0);
        chk("arst_o_ready", 32'(o_ready), 0);
        reset_dut();
        push(1, 8'h91, 1);
        push(0, 8'h92, 1);
        drive_inputs();
        run_idle("arst");
        want = '{11'h492, 11'h591};
        chk_log("arst_seq");

        // Three-channel build: out-of-range select grants nothing.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("oob_o_ready3", 32'(o_ready3), 0);
            chk("oob_o_valid3", 32'(o_valid3), 0);
        end
        sel3 = 2'd2;
        cycle();
        chk("ch3_o_valid3", 32'(o_valid3), 1);
        chk("ch3_o_data3", 32'(o_data3), 32'hC2);
        chk("ch3_o_chan3", 32'(o_chan3), 2);
        chk("ch3_o_last3", 32'(o_last3), 1);
        chk("ch3_o_ready3", 32'(o_ready3), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
